alu_seq: RTL and testbench

Parametrised, registered successor of the datapath ALU. It accepts one operation at a time over a valid/ready handshake and computes single-cycle ops with one cycle of latency. It adds an iterative unsigned multiply and a logical shift-left. Results and flags are registered and held until consumed, so the block can sit between pipeline stages or drive a multi-cycle execute unit.

---
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake: single-cycle ops in one clock,
// iterative shift-add unsigned multiply over WIDTH clocks, results held until consumed.
module alu_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int unsigned SHW     = $clog2(WIDTH);
    localparam logic [SHW:0] CntOne  = (SHW + 1)'(1);
    localparam logic [SHW:0] CntLast = (SHW + 1)'(WIDTH - 1);

    localparam logic [2:0] OpPass = 3'b000;
    localparam logic [2:0] OpMul  = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpAnd  = 3'b100;
    localparam logic [2:0] OpOr   = 3'b101;
    localparam logic [2:0] OpXor  = 3'b110;
    localparam logic [2:0] OpLsl  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, zero_q;
    logic               ovf_q, ovf_d;
    logic               cy_q, cy_d;
    logic               load_res;

    logic [2*WIDTH-1:0] prod_q, step_prod, prod_next;
    logic [WIDTH-1:0]   mcand_q, step_mcand;
    logic [WIDTH:0]     mul_sum;
    logic [SHW:0]       cnt_q;

    logic               accept, is_mul, mul_start, take_alu;

    logic [WIDTH-1:0]   b_eff, alu_res;
    logic [WIDTH:0]     add_sum;
    logic               add_cin, msb_cin, alu_ovf, alu_cy;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StDone:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (reset) begin
            in_ready = 1'b0;
        end
    end

    assign accept    = in_valid && in_ready;
    assign is_mul    = (cntrl == OpMul);
    assign mul_start = accept && is_mul;
    assign take_alu  = accept && !is_mul;

    // SUB reuses the adder as A + ~B + 1.
    always_comb begin
        add_cin = (cntrl == OpSub);
        b_eff   = add_cin ? ~B : B;
        add_sum = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
        msb_cin = add_sum[WIDTH-1] ^ A[WIDTH-1] ^ b_eff[WIDTH-1];
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cy  = 1'b0;
        case (cntrl)
            OpPass: alu_res = B;
            OpAdd, OpSub: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_cy  = add_sum[WIDTH];
                alu_ovf = msb_cin ^ add_sum[WIDTH];
            end
            OpAnd:   alu_res = A & B;
            OpOr:    alu_res = A | B;
            OpXor:   alu_res = A ^ B;
            OpLsl:   alu_res = A << B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // The accept edge performs the first multiply iteration directly from the inputs.
    always_comb begin
        step_prod  = mul_start ? {{WIDTH{1'b0}}, B} : prod_q;
        step_mcand = mul_start ? A : mcand_q;
        mul_sum    = {1'b0, step_prod[2*WIDTH-1:WIDTH]}
                   + (step_prod[0] ? {1'b0, step_mcand} : {(WIDTH + 1){1'b0}});
        prod_next  = {mul_sum, step_prod[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        cy_d     = cy_q;
        load_res = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mul_start) begin
                    state_d = StMul;
                end else if (take_alu) begin
                    state_d = StDone;
                end
            end
            StMul: begin
                if (cnt_q == CntLast) begin
                    state_d  = StDone;
                    result_d = prod_next[WIDTH-1:0];
                    ovf_d    = 1'b0;
                    cy_d     = |prod_next[2*WIDTH-1:WIDTH];
                    load_res = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    if (mul_start) begin
                        state_d = StMul;
                    end else if (take_alu) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (take_alu) begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            cy_d     = alu_cy;
            load_res = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cy_q     <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            cy_q     <= cy_d;
            // Flags are captured with the result so a reset-cleared block reports all zeros.
            if (load_res) begin
                neg_q  <= result_d[WIDTH-1];
                zero_q <= (result_d == '0);
            end
            if (mul_start) begin
                prod_q  <= prod_next;
                mcand_q <= A;
                cnt_q   <= CntOne;
            end else if (state_q == StMul) begin
                prod_q <= prod_next;
                cnt_q  <= cnt_q + CntOne;
            end
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at accept, popped when the
// DUT presents its output.
module tb_alu_seq;

    typedef struct packed {
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        o;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    alu_seq #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t         e;
        logic [64:0]  s;
        logic [127:0] p;
        e = '0;
        case (op)
            3'b000: e.res = b;
            3'b001: begin
                p     = {64'd0, a} * {64'd0, b};
                e.res = p[63:0];
                e.c   = |p[127:64];
            end
            3'b010: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[63:0];
                e.c   = s[64];
                e.o   = (a[63] == b[63]) && (s[63] != a[63]);
            end
            3'b011: begin
                s     = {1'b0, a} + {1'b0, ~b} + 65'd1;
                e.res = s[63:0];
                e.c   = s[64];
                e.o   = (a[63] != b[63]) && (s[63] != a[63]);
            end
            3'b100:  e.res = a & b;
            3'b101:  e.res = a | b;
            3'b110:  e.res = a ^ b;
            default: e.res = a << b[5:0];
        endcase
        e.n = e.res[63];
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    // Offer one op, wait (bounded) for the accept edge, queue its expectation.
    // Returns 1ns after the accept edge with in_valid low.
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input exp_t e);
        bit ok = 0;
        in_valid = 1'b1;
        cntrl    = op;
        A        = a;
        B        = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready got 0 for 200 cycles, want 1");
        end else begin
            sb.push_back(e);
        end
    endtask

    // Counts negedges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        cntrl     = 3'b010;
        A         = 64'd3;
        B         = 64'd4;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, negative, zero, overflow, carry_out} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b r=%h nzoc=%b%b%b%b want all 0",
                     out_valid, result, negative, zero, overflow, carry_out);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int   n;
        exp_t e;
        send(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, {64'h8000_0000_0000_0000, 4'b1010});
        wait_out(n);
        n_cmp++;
        if (n !== 1) begin
            n_err++;
            $display("FAIL add_latency: got %0d want 1", n);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL add_result: got %h/%b%b%b%b want %h", result, negative, zero,
                     overflow, carry_out, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub();
        int   n;
        exp_t e;
        send(3'b011, 64'd5, 64'd5, {64'd0, 4'b0101});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 1 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL sub_equal: got lat=%0d %h/%b%b%b%b want lat=1 %h", n, result,
                     negative, zero, overflow, carry_out, e);
        end
        @(posedge clk);
        #1;
        send(3'b011, 64'd0, 64'd1, {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 1 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL sub_borrow: got lat=%0d %h/%b%b%b%b want lat=1 %h", n, result,
                     negative, zero, overflow, carry_out, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold();
        int   n;
        int   bad = 0;
        exp_t e;
        out_ready = 1'b0;
        send(3'b110, 64'hF0F0, 64'hFFFF, {64'h0F0F, 4'b0000});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 1 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL hold_xor: got lat=%0d %h want lat=1 %h", n, result, e.res);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result !== 64'h0F0F || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'b100, 64'hFF00, 64'h0FF0, {64'h0F00, 4'b0000});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 1 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL hold_release_and: got lat=%0d %h want lat=1 %h", n, result,
                     e.res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        int   n = -1;
        int   rdy_hi = 0;
        exp_t e;
        send(3'b001, 64'hFFFF_FFFF, 64'h1_0000_0001, {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
            if (in_ready) rdy_hi++;
        end
        n_cmp++;
        if (n !== 64 || rdy_hi != 0) begin
            n_err++;
            $display("FAIL mul_latency: got lat=%0d rdy_hi=%0d want lat=64 rdy_hi=0", n,
                     rdy_hi);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL mul_result: got %h/%b%b%b%b want %h", result, negative, zero,
                     overflow, carry_out, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul_reset();
        int   n;
        int   seen = 0;
        exp_t e;
        send(3'b001, 64'h8000_0000_0000_0000, 64'd4, {64'd0, 4'b0101});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 64 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL mul_high: got lat=%0d %h/%b%b%b%b want lat=64 %h", n, result,
                     negative, zero, overflow, carry_out, e);
        end
        @(posedge clk);
        #1;
        send(3'b001, 64'd3, 64'd5, model(3'b001, 64'd3, 64'd5));
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mulrst_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, result, negative, zero, overflow, carry_out} !==
            {1'b1, 69'd0}) begin
            n_err++;
            $display("FAIL mulrst_outputs: got rdy=%b v=%b r=%h nzoc=%b%b%b%b want 1/0/0/0000",
                     in_ready, out_valid, result, negative, zero, overflow, carry_out);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL mulrst_discard: got out_valid high %0d cycles want 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsl_pass();
        int   n;
        exp_t e;
        send(3'b111, 64'd1, 64'h43, {64'd8, 4'b0000});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 1 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL lsl: got %h/%b%b%b%b want %h", result, negative, zero, overflow,
                     carry_out, e);
        end
        @(posedge clk);
        #1;
        send(3'b000, 64'd7, 64'h8000_0000_0000_0000, {64'h8000_0000_0000_0000, 4'b1000});
        wait_out(n);
        e = sb.pop_front();
        n_cmp++;
        if (n !== 1 || {result, negative, zero, overflow, carry_out} !== e) begin
            n_err++;
            $display("FAIL pass: got %h/%b%b%b%b want %h", result, negative, zero, overflow,
                     carry_out, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[8] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000,
                                3'b011};
        logic [63:0] a;
        logic [63:0] b;
        int          c0 = 0;
        int          c1 = 0;
        exp_t        e;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send(ops[k], a, b, model(ops[k], a, b));
            if (k == 0) c0 = cyc;
            if (k == 7) c1 = cyc;
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {result, negative, zero, overflow, carry_out} !== e)
                begin
                n_err++;
                $display("FAIL b2b_op%0d: got v=%b %h/%b%b%b%b want %h", k, out_valid, result,
                         negative, zero, overflow, carry_out, e);
            end
        end
        n_cmp++;
        if (c1 - c0 != 7) begin
            n_err++;
            $display("FAIL b2b_throughput: got %0d cycles for 8 ops want 7", c1 - c0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_hold();
        test_mul();
        test_mul_reset();
        test_lsl_pass();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
